// File: rtl/gf128_pp_accumulator.sv
// Folds reduced, word-positioned GF(2^128) partial products into a 128-bit accumulator
// and hands the finished word to the result path over a valid/ready handshake.
module gf128_pp_accumulator #(
  parameter int NUM_PP = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         pp_valid_i,
  output logic         pp_ready_o,
  input  logic [31:0]  pp_c0_i,
  input  logic [31:0]  pp_c1_i,
  input  logic [5:0]   pp_c3_i,
  input  logic [2:0]   pp_shift_idx_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [127:0] res_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam int CNT_W = $clog2(NUM_PP) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_reg;
  logic [3:0][31:0]  acc_reg;
  logic [3:0][31:0]  acc_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;

  logic       beat_accept;
  logic       shift_legal;
  logic       c3_used;
  logic [1:0] pos0;
  logic [1:0] pos1;
  logic [1:0] pos2;

  assign beat_accept = pp_valid_i && (state_reg == ACCUM);
  assign shift_legal = (pp_shift_idx_i != 3'd7);
  assign c3_used     = (pp_shift_idx_i >= 3'd3);
  // Word positions wrap modulo 4 through the natural 2-bit overflow.
  assign pos0 = pp_shift_idx_i[1:0];
  assign pos1 = pos0 + 2'd1;
  assign pos2 = pos0 + 2'd2;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      logic [31:0] mask;
      always_comb begin
        mask = 32'd0;
        if (pos0 == 2'(gi)) mask = mask ^ pp_c0_i;
        if (pos1 == 2'(gi)) mask = mask ^ pp_c1_i;
        if (c3_used && (pos2 == 2'(gi))) mask = mask ^ {26'd0, pp_c3_i};
        acc_next[gi] = shift_legal ? (acc_reg[gi] ^ mask) : acc_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
          end
        end
        ACCUM: begin
          if (beat_accept) begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (!shift_legal) err_reg <= 1'b1;
            if (cnt_reg == LAST_CNT) state_reg <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pp_ready_o  = (state_reg == ACCUM);
  assign res_valid_o = (state_reg == DONE);
  assign busy_o      = (state_reg == ACCUM) || (state_reg == DONE);
  assign err_o       = err_reg;
  assign res_o       = acc_reg;

endmodule
